// File: rtl/duc_dac_pkg.sv
// Shared types, widths and sine ROM for the DA2 sine generator.
package duc_dac_pkg;

   localparam int SAMPLE_W       = 8;
   localparam int DAC_WORD_W     = 16;
   localparam int DAC_DATA_W     = 12;
   localparam int SAMPLE_DIV_DEF = 64;
   localparam int LUT_AW_DEF     = 6;
   localparam int ROM_AW         = 6;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE_ST
   } ser_state_t;

   // First quarter wave, round(127*sin(2*pi*k/64)) for k = 0..16.
   function automatic logic [6:0] sine_amp(input logic [4:0] k);
      logic [6:0] amp;
      case (k)
         5'd0:    amp = 7'd0;
         5'd1:    amp = 7'd12;
         5'd2:    amp = 7'd25;
         5'd3:    amp = 7'd37;
         5'd4:    amp = 7'd49;
         5'd5:    amp = 7'd60;
         5'd6:    amp = 7'd71;
         5'd7:    amp = 7'd81;
         5'd8:    amp = 7'd90;
         5'd9:    amp = 7'd98;
         5'd10:   amp = 7'd106;
         5'd11:   amp = 7'd112;
         5'd12:   amp = 7'd117;
         5'd13:   amp = 7'd122;
         5'd14:   amp = 7'd125;
         5'd15:   amp = 7'd126;
         default: amp = 7'd127;
      endcase
      return amp;
   endfunction

   // Full 64-entry table folded onto the quarter wave by symmetry.
   function automatic logic [SAMPLE_W-1:0] sine_lut(input logic [ROM_AW-1:0] addr);
      logic [4:0] r;
      logic [4:0] f;
      logic [6:0] amp;
      r   = addr[4:0];
      f   = r[4] ? 5'(6'd32 - {1'b0, r}) : r;
      amp = sine_amp(f);
      return addr[5] ? (8'd128 - {1'b0, amp}) : (8'd128 + {1'b0, amp});
   endfunction

endpackage

// File: rtl/duc_dac_sine_if.sv
// Sample output and Pmod DA2 connector signals of the sine generator.
interface duc_dac_sine_if;
   import duc_dac_pkg::*;

   logic [SAMPLE_W-1:0] phase;
   logic                D1;
   logic                D2;
   logic                CLK_OUT;
   logic                nSYNC;
   logic                DONE;

   modport master (
      output phase,
      output D1,
      output D2,
      output CLK_OUT,
      output nSYNC,
      output DONE
   );

   modport slave (
      input phase,
      input D1,
      input D2,
      input CLK_OUT,
      input nSYNC,
      input DONE
   );
endinterface

// File: rtl/duc_dac_sine_serializer.sv
// Pmod DA2 (dual DAC121S101) frame serializer: 16 bits per channel, SCLK = clk_in/2.
//   state   | meaning
//   IDLE    | nSYNC high, CLK_OUT high, waiting for start
//   SHIFT   | nSYNC low, 16 SCLK periods, data changes on SCLK rising edge
//   DONE_ST | nSYNC back high, one-cycle DONE pulse
module da2_serializer
   import duc_dac_pkg::*;
(
   input  logic                  clk_in,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DAC_DATA_W-1:0] data_a,
   input  logic [DAC_DATA_W-1:0] data_b,
   output logic                  D1,
   output logic                  D2,
   output logic                  CLK_OUT,
   output logic                  nSYNC,
   output logic                  DONE
);

   ser_state_t  state, state_nx;
   logic [14:0] sh_a, sh_a_nx;
   logic [14:0] sh_b, sh_b_nx;
   logic [4:0]  bit_cnt, bit_cnt_nx;
   logic        d1_nx, d2_nx, sclk_nx, nsync_nx, done_nx;

   logic [DAC_WORD_W-1:0] word_a;
   logic [DAC_WORD_W-1:0] word_b;

   assign word_a = {4'b0000, data_a};
   assign word_b = {4'b0000, data_b};

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         sh_a    <= '0;
         sh_b    <= '0;
         bit_cnt <= '0;
         D1      <= 1'b0;
         D2      <= 1'b0;
         CLK_OUT <= 1'b1;
         nSYNC   <= 1'b1;
         DONE    <= 1'b0;
      end else begin
         state   <= state_nx;
         sh_a    <= sh_a_nx;
         sh_b    <= sh_b_nx;
         bit_cnt <= bit_cnt_nx;
         D1      <= d1_nx;
         D2      <= d2_nx;
         CLK_OUT <= sclk_nx;
         nSYNC   <= nsync_nx;
         DONE    <= done_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      sh_a_nx    = sh_a;
      sh_b_nx    = sh_b;
      bit_cnt_nx = bit_cnt;
      d1_nx      = D1;
      d2_nx      = D2;
      sclk_nx    = CLK_OUT;
      nsync_nx   = nSYNC;
      done_nx    = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_nx   = SHIFT;
               sh_a_nx    = word_a[14:0];
               sh_b_nx    = word_b[14:0];
               d1_nx      = word_a[15];
               d2_nx      = word_b[15];
               bit_cnt_nx = '0;
               sclk_nx    = 1'b1;
               nsync_nx   = 1'b0;
            end
         end
         SHIFT: begin
            bit_cnt_nx = bit_cnt + 5'd1;
            // Cycle 31 is the rising edge after the 16th falling edge.
            if (bit_cnt == 5'd31) begin
               state_nx = DONE_ST;
               sclk_nx  = 1'b1;
               nsync_nx = 1'b1;
               d1_nx    = 1'b0;
               d2_nx    = 1'b0;
               done_nx  = 1'b1;
            end else begin
               sclk_nx = ~CLK_OUT;
               if (!CLK_OUT) begin
                  d1_nx   = sh_a[14];
                  d2_nx   = sh_b[14];
                  sh_a_nx = {sh_a[13:0], 1'b0};
                  sh_b_nx = {sh_b[13:0], 1'b0};
               end
            end
         end
         DONE_ST: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: rtl/duc_dac_sine.sv
// Sine sample generator driving channel A of a Pmod DA2; channel B is held at zero.
module duc_dac_sine
   import duc_dac_pkg::*;
#(
   parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
   parameter int LUT_AW     = LUT_AW_DEF
) (
   input  logic    clk_in,
   input  logic    rst,
   duc_dac_sine_if.master da2
);

   localparam int CNT_W     = $clog2(SAMPLE_DIV);
   localparam int ROM_SHIFT = ROM_AW - LUT_AW;

   logic [CNT_W-1:0]    cnt;
   logic                tick;
   logic                start;
   logic [LUT_AW-1:0]   idx;
   logic [LUT_AW-1:0]   idx_nx;
   logic [ROM_AW-1:0]   rom_addr;
   logic [SAMPLE_W-1:0] phase_q;
   logic [DAC_DATA_W-1:0] data_a;
   logic [DAC_DATA_W-1:0] data_b;

   assign tick   = (cnt == CNT_W'(SAMPLE_DIV - 1));
   assign idx_nx = idx + 1'b1;
   // Shorter tables step through the 64-entry ROM with a coarser stride.
   assign rom_addr = ROM_AW'(idx_nx) << ROM_SHIFT;

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         cnt     <= '0;
         idx     <= '0;
         phase_q <= 8'd128;
         start   <= 1'b0;
      end else begin
         start <= tick;
         if (tick) begin
            cnt     <= '0;
            idx     <= idx_nx;
            phase_q <= sine_lut(rom_addr);
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign data_a    = {1'b0, phase_q, 3'b000};
   assign data_b    = '0;
   assign da2.phase = phase_q;

   da2_serializer u_ser (
      .clk_in  (clk_in),
      .rst     (rst),
      .start   (start),
      .data_a  (data_a),
      .data_b  (data_b),
      .D1      (da2.D1),
      .D2      (da2.D2),
      .CLK_OUT (da2.CLK_OUT),
      .nSYNC   (da2.nSYNC),
      .DONE    (da2.DONE)
   );

endmodule

// File: tb/tb_duc_dac_sine.sv
// Bench for duc_dac_sine: cycle model from elapsed time, DAC frame capture, table and reset sequences.
module tb_duc_dac_sine;
   import duc_dac_pkg::*;

   localparam int SD   = 64;
   localparam int AW   = 6;
   localparam int NLUT = 1 << AW;
   localparam int MAXF = 70;

   logic clk_in = 1'b0;
   logic rst    = 1'b1;

   always #5 clk_in = ~clk_in;

   duc_dac_sine_if da2();

   duc_dac_sine #(.SAMPLE_DIV(SD), .LUT_AW(AW)) dut (
      .clk_in (clk_in),
      .rst    (rst),
      .da2    (da2)
   );

   int n_pass  = 0;
   int n_total = 0;
   int n_cyc   = 0;

   typedef struct {
      int tick;
      int phase;
      int word;
   } vec_t;

   vec_t vecs[6];

   int cap_word[0:MAXF];
   int cap_phase[0:MAXF];
   int fr = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s at n=%0d t=%0t: got %0d expected %0d", name, n_cyc, $time, act, exp);
   endtask

   function automatic int lut(input int k);
      real a;
      a = 2.0 * 3.141592653589793 * real'(k) / real'(NLUT);
      return $rtoi($floor(128.0 + 127.0 * $sin(a) + 0.5));
   endfunction

   // Clock edges seen with reset released since the last reset.
   always @(posedge clk_in or negedge rst) begin
      if (!rst) n_cyc <= 0;
      else      n_cyc <= n_cyc + 1;
   end

   // Expected waveform from elapsed cycles, plus a DAC-side frame capture.
   int   k, m, ph, w, ex_sync, ex_sclk, ex_done, ex_d1;
   bit   in_frame;
   bit   prev_sync = 1'b1;
   bit   prev_sclk = 1'b1;
   int   bits = 0;
   int   n_fall = -1000;
   int   fr_phase = 0;
   logic [15:0] wa, wb;

   always @(negedge clk_in) begin
      k        = n_cyc / SD;
      m        = n_cyc - k * SD;
      ph       = lut(k % NLUT);
      w        = ph * 8;
      in_frame = (k >= 1) && (m >= 1) && (m <= 32);
      ex_sync  = in_frame ? 0 : 1;
      ex_sclk  = in_frame ? (m % 2) : 1;
      ex_done  = (k >= 1 && m == 33) ? 1 : 0;
      ex_d1    = in_frame ? ((w >> (15 - (m - 1) / 2)) & 1) : 0;

      check("phase",   int'(da2.phase),   ph);
      check("nSYNC",   int'(da2.nSYNC),   ex_sync);
      check("CLK_OUT", int'(da2.CLK_OUT), ex_sclk);
      check("DONE",    int'(da2.DONE),    ex_done);
      check("D1",      int'(da2.D1),      ex_d1);
      check("D2",      int'(da2.D2),      0);
      if (dut.start) check("start_in_idle", int'(dut.u_ser.state), int'(IDLE));

      if (!rst) begin
         prev_sync = 1'b1;
         prev_sclk = 1'b1;
         bits      = 0;
         fr        = 0;
         n_fall    = -1000;
      end else begin
         if (prev_sync && !da2.nSYNC) begin
            bits     = 0;
            wa       = '0;
            wb       = '0;
            n_fall   = n_cyc;
            fr_phase = int'(da2.phase);
            check("sync_fall_after_tick", n_cyc % SD, 1);
         end
         if (!da2.nSYNC && prev_sclk && !da2.CLK_OUT) begin
            wa = {wa[14:0], da2.D1};
            wb = {wb[14:0], da2.D2};
            bits++;
         end
         if (!prev_sync && da2.nSYNC) begin
            fr++;
            check("frame_bits",   bits, 16);
            check("frame_len",    n_cyc - n_fall, 32);
            check("frame_word_a", int'(wa), lut(fr % NLUT) * 8);
            check("frame_word_b", int'(wb), 0);
            if (fr <= MAXF) begin
               cap_word[fr]  = int'(wa);
               cap_phase[fr] = fr_phase;
            end
         end
         if (da2.DONE) check("done_delay", n_cyc - n_fall, 32);
         prev_sync = da2.nSYNC;
         prev_sclk = da2.CLK_OUT;
      end
   end

   task automatic wait_n(input int target);
      int budget;
      budget = target + 200;
      while (n_cyc < target && budget > 0) begin
         @(negedge clk_in);
         budget--;
      end
      if (n_cyc != target) check("wait_target", n_cyc, target);
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_phase"},   int'(da2.phase),   128);
      check({tag, "_nSYNC"},   int'(da2.nSYNC),   1);
      check({tag, "_CLK_OUT"}, int'(da2.CLK_OUT), 1);
      check({tag, "_DONE"},    int'(da2.DONE),    0);
      check({tag, "_D1"},      int'(da2.D1),      0);
   endtask

   initial begin
      int off, nt, hold;
      vecs[0] = '{tick: 1,  phase: 140, word: 16'h0460};
      vecs[1] = '{tick: 16, phase: 255, word: 16'h07F8};
      vecs[2] = '{tick: 32, phase: 128, word: 16'h0400};
      vecs[3] = '{tick: 48, phase: 1,   word: 16'h0008};
      vecs[4] = '{tick: 63, phase: 116, word: 16'h03A0};
      vecs[5] = '{tick: 64, phase: 128, word: 16'h0400};

      #1 rst = 1'b0;
      #1 reset_checks("rst_t2");
      #10 reset_checks("rst_t12");
      #5 rst = 1'b1;

      wait_n(SD - 1);
      check("pre_first_tick_phase", int'(da2.phase), 128);
      wait_n(SD);
      check("first_tick_phase", int'(da2.phase), 140);

      wait_n(SD * NLUT + 40);
      check("frames_per_tick", fr, NLUT);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("tbl_phase_t%0d", vecs[i].tick), cap_phase[vecs[i].tick], vecs[i].phase);
         check($sformatf("tbl_word_t%0d", vecs[i].tick), cap_word[vecs[i].tick], vecs[i].word);
      end

      wait_n(SD * (NLUT + 1) + 11);
      #2 rst = 1'b0;
      #1 reset_checks("midframe");
      repeat (3) @(negedge clk_in);
      #2 rst = 1'b1;
      wait_n(SD);
      check("restart_phase", int'(da2.phase), 140);
      wait_n(2 * SD + 40);
      check("restart_frames", fr, 2);

      for (int r = 0; r < 5; r++) begin
         nt   = $urandom_range(1, 3);
         off  = $urandom_range(1, SD - 1);
         hold = $urandom_range(1, 4);
         wait_n(nt * SD + off);
         #2 rst = 1'b0;
         #1 reset_checks("rand_rst");
         repeat (hold) @(negedge clk_in);
         #2 rst = 1'b1;
      end
      wait_n(3 * SD + 40);
      check("final_frames", fr, 3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
